pci_cfg_master: RTL and testbench
=================================

PCI_CFG_MASTER -- requirements
Module: pci_cfg_master

Interface
REQ-001 Parameter DEVSEL_TMO, default 5: clocks after address phase with no DEVSEL# before master abort.
REQ-002 Parameter RETRY_MAX, default 16: retry terminations accepted before status "retry exhausted".
REQ-003 clk  input  1  PCI clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  request a config cycle; sampled only in IDLE.
REQ-006 req_we  input  1  1 = config write (C/BE 1011), 0 = config read (C/BE 1010).
REQ-007 req_dev  input  4  device number; selects IDSEL line AD[16+req_dev].
REQ-008 req_reg  input  6  dword register number, driven on AD[7:2].
REQ-009 req_be  input  4  byte enables for the data phase, active-high.
REQ-010 req_wdata  input  32  write data.
REQ-011 req_done  output  1  one-cycle pulse when the cycle completes.
REQ-012 rsp_rdata  output  32  read data, valid with req_done.
REQ-013 rsp_status  output  2  00 ok, 01 master abort, 10 target abort, 11 retry exhausted.
REQ-014 req_n / gnt_n  output / input  1  PCI arbiter request/grant, active-low.
REQ-015 frame_n_i, irdy_n_i, trdy_n_i, devsel_n_i, stop_n_i  input  1 each  sampled bus controls.
REQ-016 ad_i  input  32  sampled AD bus.
REQ-017 ad_o, ad_oe  output  32, 1  AD drive value and enable.
REQ-018 cbe_o, cbe_oe  output  4, 1  C/BE# drive value (active-low enables) and enable.
REQ-019 par_o, par_oe  output  1, 1  even parity over the previous cycle's ad_o and cbe_o, and enable.
REQ-020 frame_n_o, irdy_n_o, ctl_oe  output  1, 1, 1  FRAME#/IRDY# drive and enable.

Function
REQ-021 States: IDLE, ARB, ADDR, DATA, TURN, DONE.
REQ-022 IDLE -> ARB when req=1; latch all req_* fields; clear retry count; req_n=0.
REQ-023 ARB -> ADDR when gnt_n=0, frame_n_i=1 and irdy_n_i=1 sampled in the same cycle.
REQ-024 ADDR, one clock: frame_n_o=0, irdy_n_o=1, ad_o = one-hot AD[16+dev], AD[10:8]=000, AD[7:2]=reg, AD[1:0]=00; cbe_o per REQ-006; ad_oe, cbe_oe, ctl_oe=1; req_n=1.
REQ-025 DATA: frame_n_o=1, irdy_n_o=0, cbe_o=~be; on writes ad_oe=1 with wdata; on reads ad_oe=0 (turnaround).
REQ-026 DATA, trdy_n_i=0 and devsel_n_i=0: capture ad_i when reading; status 00; -> TURN.
REQ-027 DATA, stop_n_i=0, trdy_n_i=1, devsel_n_i=0: retry; count+1; -> TURN, then ARB; when count reaches RETRY_MAX, status 11 and TURN -> DONE.
REQ-028 DATA, stop_n_i=0 and devsel_n_i=1 after DEVSEL was asserted earlier in the phase: target abort, status 10.
REQ-029 DATA, devsel_n_i=1 for DEVSEL_TMO clocks counted from the ADDR clock: master abort, status 01, rsp_rdata=FFFFFFFF.
REQ-030 trdy_n_i=0 and stop_n_i=0 together = disconnect with data: completes as REQ-026.
REQ-031 TURN, one clock: irdy_n_o=1 driven; ad_oe=cbe_oe=0; ctl_oe=1; the following clock ctl_oe=0.
REQ-032 par_oe follows ad_oe delayed one clock; par_o = XOR of prior ad_o and cbe_o.
REQ-033 DONE: req_done=1 for one clock; -> IDLE; req is ignored during DONE.
REQ-034 Latency, fast target (DEVSEL and TRDY asserted on the first DATA clock), grant already held: req to req_done = 5 clocks.

Reset
REQ-035 Reset, asynchronous, taking effect mid-cycle: state IDLE; req_n=1; frame_n_o=irdy_n_o=1; all *_oe=0; req_done=0; rsp_rdata=0; rsp_status=00; counters 0.

Structure
REQ-036 Shared package pci_pkg: state encoding, C/BE command constants CFGRD=1010/CFGWR=1011, status codes.
REQ-037 Single module with one sub-module pci_par_gen (registered parity), reusable by other initiators.

Verification
REQ-038 Write dev=3, reg=04, be=F, wdata=00000007; target asserts DEVSEL and TRDY on DATA clock 1 -> ADDR AD=00080010, C/BE=1011, status 00, req_done 5 clocks after req.
REQ-039 Read dev=0, reg=00; target drives 12345678 -> rsp_rdata=12345678, status 00, ad_oe=0 throughout DATA.
REQ-040 Read with no DEVSEL -> master abort after 5 clocks, rsp_rdata=FFFFFFFF, status 01.
REQ-041 Target retries 16 times -> 16 re-arbitrations, status 11; after 3 retries then TRDY -> status 00.
REQ-042 Assert rst during DATA -> all *_oe=0 and req_n=1 immediately; next req after reset starts cleanly from IDLE.
REQ-043 Parity check: par_o one clock after each ADDR/DATA clock equals even parity of AD and C/BE.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared definitions for PCI configuration initiators: FSM states, C/BE commands,
// completion status codes and the Type-0 configuration address builder.
package pci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ADDR,
        ST_DATA,
        ST_TURN,
        ST_DONE
    } state_t;

    localparam logic [3:0] CMD_CFGRD = 4'b1010;
    localparam logic [3:0] CMD_CFGWR = 4'b1011;

    localparam logic [1:0] STS_OK     = 2'b00;
    localparam logic [1:0] STS_MABORT = 2'b01;
    localparam logic [1:0] STS_TABORT = 2'b10;
    localparam logic [1:0] STS_RETRY  = 2'b11;

    // IDSEL is a one-hot line in AD[31:16]; function number and type bits stay zero.
    function automatic logic [31:0] cfg_addr(input logic [3:0] dev, input logic [5:0] regnum);
        logic [31:0] a;
        a            = 32'h0;
        a[16 + dev]  = 1'b1;
        a[7:2]       = regnum;
        return a;
    endfunction

endpackage

// File: rtl/pci_par_gen.sv
// Registered PCI PAR generator: even parity over the previous clock's AD and C/BE#,
// with the output enable trailing the AD enable by one clock.
module pci_par_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ad,
    input  logic [3:0]  cbe,
    input  logic        oe,
    output logic        par,
    output logic        par_oe
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par    <= 1'b0;
            par_oe <= 1'b0;
        end else begin
            par    <= ^{ad, cbe};
            par_oe <= oe;
        end
    end

endmodule

// File: rtl/pci_cfg_master.sv
// PCI Type-0 configuration-cycle initiator: arbitrates, issues one single-dword
// config read or write, and handles retry, target abort and master abort.
module pci_cfg_master
    import pci_pkg::*;
#(
    parameter int DEVSEL_TMO = 5,
    parameter int RETRY_MAX  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [3:0]  req_dev,
    input  logic [5:0]  req_reg,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        req_done,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic        req_n,
    input  logic        gnt_n,
    input  logic        frame_n_i,
    input  logic        irdy_n_i,
    input  logic        trdy_n_i,
    input  logic        devsel_n_i,
    input  logic        stop_n_i,
    input  logic [31:0] ad_i,
    output logic [31:0] ad_o,
    output logic        ad_oe,
    output logic [3:0]  cbe_o,
    output logic        cbe_oe,
    output logic        par_o,
    output logic        par_oe,
    output logic        frame_n_o,
    output logic        irdy_n_o,
    output logic        ctl_oe
);

    localparam int RC_W  = $clog2(RETRY_MAX + 1);
    localparam int TMO_W = $clog2(DEVSEL_TMO + 1);

    state_t            state, state_nxt;
    logic              we_q;
    logic [3:0]        dev_q;
    logic [5:0]        reg_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [RC_W-1:0]   retry_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              devsel_seen;
    logic              retry_again;
    logic              ev_ok, ev_retry, ev_tabort, ev_mabort;
    logic              retry_last;

    assign retry_last = (retry_cnt + RC_W'(1)) == RC_W'(RETRY_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ev_ok     = 1'b0;
        ev_retry  = 1'b0;
        ev_tabort = 1'b0;
        ev_mabort = 1'b0;
        req_n     = 1'b1;
        frame_n_o = 1'b1;
        irdy_n_o  = 1'b1;
        ad_o      = 32'h0;
        ad_oe     = 1'b0;
        cbe_o     = 4'h0;
        cbe_oe    = 1'b0;
        ctl_oe    = 1'b0;
        req_done  = 1'b0;
        case (state)
            ST_IDLE: if (req) state_nxt = ST_ARB;
            ST_ARB: begin
                req_n = 1'b0;
                if (!gnt_n && frame_n_i && irdy_n_i) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                frame_n_o = 1'b0;
                ad_o      = cfg_addr(dev_q, reg_q);
                cbe_o     = we_q ? CMD_CFGWR : CMD_CFGRD;
                ad_oe     = 1'b1;
                cbe_oe    = 1'b1;
                ctl_oe    = 1'b1;
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                irdy_n_o = 1'b0;
                cbe_o    = ~be_q;
                cbe_oe   = 1'b1;
                ctl_oe   = 1'b1;
                ad_o     = we_q ? wdata_q : 32'h0;
                ad_oe    = we_q;
                // TRDY wins over STOP: a disconnect-with-data still transfers the dword.
                if (!devsel_n_i && !trdy_n_i)
                    ev_ok = 1'b1;
                else if (!devsel_n_i && !stop_n_i)
                    ev_retry = 1'b1;
                else if (devsel_n_i && !stop_n_i && devsel_seen)
                    ev_tabort = 1'b1;
                else if (devsel_n_i && !devsel_seen && tmo_cnt >= TMO_W'(DEVSEL_TMO - 1))
                    ev_mabort = 1'b1;
                if (ev_ok || ev_retry || ev_tabort || ev_mabort) state_nxt = ST_TURN;
            end
            ST_TURN: begin
                ctl_oe    = 1'b1;
                state_nxt = retry_again ? ST_ARB : ST_DONE;
            end
            ST_DONE: begin
                req_done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q        <= 1'b0;
            dev_q       <= 4'h0;
            reg_q       <= 6'h0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            retry_cnt   <= '0;
            tmo_cnt     <= '0;
            devsel_seen <= 1'b0;
            retry_again <= 1'b0;
            rsp_rdata   <= 32'h0;
            rsp_status  <= STS_OK;
        end else begin
            case (state)
                ST_IDLE: if (req) begin
                    we_q      <= req_we;
                    dev_q     <= req_dev;
                    reg_q     <= req_reg;
                    be_q      <= req_be;
                    wdata_q   <= req_wdata;
                    retry_cnt <= '0;
                end
                ST_ARB: begin
                    tmo_cnt     <= '0;
                    devsel_seen <= 1'b0;
                    retry_again <= 1'b0;
                end
                // The address clock itself counts toward the DEVSEL timeout.
                ST_ADDR: tmo_cnt <= TMO_W'(1);
                ST_DATA: begin
                    if (!devsel_n_i)
                        devsel_seen <= 1'b1;
                    else if (tmo_cnt < TMO_W'(DEVSEL_TMO))
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (ev_ok) begin
                        if (!we_q) rsp_rdata <= ad_i;
                        rsp_status <= STS_OK;
                    end
                    if (ev_retry) begin
                        retry_cnt <= retry_cnt + RC_W'(1);
                        if (retry_last) rsp_status <= STS_RETRY;
                        retry_again <= !retry_last;
                    end
                    if (ev_tabort) rsp_status <= STS_TABORT;
                    if (ev_mabort) begin
                        rsp_status <= STS_MABORT;
                        rsp_rdata  <= 32'hFFFF_FFFF;
                    end
                end
                default: ;
            endcase
        end
    end

    pci_par_gen u_par (
        .clk    (clk),
        .rst    (rst),
        .ad     (ad_o),
        .cbe    (cbe_o),
        .oe     (ad_oe),
        .par    (par_o),
        .par_oe (par_oe)
    );

endmodule

// File: tb/tb_pci_cfg_master.sv
// Directed bench for pci_cfg_master with a small reactive target on the bus.
module tb_pci_cfg_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_dev = 4'h0;
    logic [5:0]  req_reg = 6'h0;
    logic [3:0]  req_be = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_done;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        req_n;
    logic        gnt_n = 1'b0;
    logic        frame_n_i, irdy_n_i, trdy_n_i, devsel_n_i, stop_n_i;
    logic [31:0] ad_i;
    logic [31:0] ad_o;
    logic        ad_oe;
    logic [3:0]  cbe_o;
    logic        cbe_oe, par_o, par_oe, frame_n_o, irdy_n_o, ctl_oe;

    int          checks = 0;
    int          errors = 0;

    // target behaviour: 0 fast, 1 silent, 2 retry then ack, 3 target abort, 4 stall
    int          tgt_mode = 0;
    logic [31:0] tgt_rdata = 32'h0;
    int          retry_target = 0;
    int          retry_base = 0;
    int          retries_seen = 0;
    int          dp_cnt = 0;
    int          arb_cnt = 0;
    logic        prev_req_n = 1'b1;
    logic        data_phase;

    always #5 clk = ~clk;

    pci_cfg_master dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_we     (req_we),
        .req_dev    (req_dev),
        .req_reg    (req_reg),
        .req_be     (req_be),
        .req_wdata  (req_wdata),
        .req_done   (req_done),
        .rsp_rdata  (rsp_rdata),
        .rsp_status (rsp_status),
        .req_n      (req_n),
        .gnt_n      (gnt_n),
        .frame_n_i  (frame_n_i),
        .irdy_n_i   (irdy_n_i),
        .trdy_n_i   (trdy_n_i),
        .devsel_n_i (devsel_n_i),
        .stop_n_i   (stop_n_i),
        .ad_i       (ad_i),
        .ad_o       (ad_o),
        .ad_oe      (ad_oe),
        .cbe_o      (cbe_o),
        .cbe_oe     (cbe_oe),
        .par_o      (par_o),
        .par_oe     (par_oe),
        .frame_n_o  (frame_n_o),
        .irdy_n_o   (irdy_n_o),
        .ctl_oe     (ctl_oe)
    );

    always_comb begin
        data_phase = ctl_oe && !irdy_n_o;
        devsel_n_i = 1'b1;
        trdy_n_i   = 1'b1;
        stop_n_i   = 1'b1;
        if (data_phase) begin
            case (tgt_mode)
                0: begin devsel_n_i = 1'b0; trdy_n_i = 1'b0; end
                2: begin
                    devsel_n_i = 1'b0;
                    if (retries_seen - retry_base < retry_target) stop_n_i = 1'b0;
                    else trdy_n_i = 1'b0;
                end
                3: begin
                    if (dp_cnt == 0) devsel_n_i = 1'b0;
                    else stop_n_i = 1'b0;
                end
                4: devsel_n_i = 1'b0;
                default: ;
            endcase
        end
        frame_n_i = ctl_oe ? frame_n_o : 1'b1;
        irdy_n_i  = ctl_oe ? irdy_n_o : 1'b1;
        ad_i      = ad_oe ? ad_o : (data_phase ? tgt_rdata : 32'h0);
    end

    always @(posedge clk) begin
        if (data_phase) begin
            dp_cnt <= dp_cnt + 1;
            if (tgt_mode == 2 && !stop_n_i && trdy_n_i) retries_seen <= retries_seen + 1;
        end else begin
            dp_cnt <= 0;
        end
        prev_req_n <= req_n;
        if (!req_n && prev_req_n) arb_cnt <= arb_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_cfg(input logic we, input logic [3:0] dev, input logic [5:0] rn,
                          input logic [3:0] be, input logic [31:0] wd, input int gnt_hold,
                          output int lat, output logic [31:0] a_ad, output logic [3:0] a_cbe,
                          output logic wr_oe, output int perr);
        logic [31:0] p_ad;
        logic [3:0]  p_cbe;
        logic        p_oe;
        lat = 0; a_ad = 32'h0; a_cbe = 4'h0; wr_oe = 1'b0; perr = 0;
        @(posedge clk); #1;
        p_ad = ad_o; p_cbe = cbe_o; p_oe = ad_oe;
        req_we = we; req_dev = dev; req_reg = rn; req_be = be; req_wdata = wd;
        gnt_n = (gnt_hold > 1);
        req = 1'b1;
        while (lat < 600) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) req = 1'b0;
            if (lat == gnt_hold) gnt_n = 1'b0;
            if (par_o !== ^{p_ad, p_cbe} || par_oe !== p_oe) perr++;
            p_ad = ad_o; p_cbe = cbe_o; p_oe = ad_oe;
            if (ctl_oe && !frame_n_o) begin a_ad = ad_o; a_cbe = cbe_o; end
            if (data_phase && ad_oe) wr_oe = 1'b1;
            if (req_done) break;
        end
        @(posedge clk); #1;
        chk("done_pulse", {31'h0, req_done}, 32'h0);
    endtask

    int          lat, perr, arb0, rs0;
    logic [31:0] a_ad;
    logic [3:0]  a_cbe;
    logic        wr_oe;

    initial begin
        #12;
        chk("rst_ctl", {24'h0, req_n, frame_n_o, irdy_n_o, ad_oe, cbe_oe, ctl_oe, par_oe, req_done},
            32'h0000_00E0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_status", {30'h0, rsp_status}, 32'h0);
        rst = 1'b1;

        // Fast write: dev 3, reg 4
        tgt_mode = 0;
        do_cfg(1'b1, 4'd3, 6'd4, 4'hF, 32'h0000_0007, 1, lat, a_ad, a_cbe, wr_oe, perr);
        chk("wr_latency", lat, 5);
        chk("wr_addr", a_ad, 32'h0008_0010);
        chk("wr_cmd", {28'h0, a_cbe}, 32'hB);
        chk("wr_status", {30'h0, rsp_status}, 32'h0);
        chk("wr_ad_oe", {31'h0, wr_oe}, 32'h1);
        chk("wr_parity", perr, 0);

        // Fast read: dev 0, reg 0
        tgt_rdata = 32'h1234_5678;
        do_cfg(1'b0, 4'd0, 6'd0, 4'hF, 32'h0, 1, lat, a_ad, a_cbe, wr_oe, perr);
        chk("rd_latency", lat, 5);
        chk("rd_addr", a_ad, 32'h0001_0000);
        chk("rd_cmd", {28'h0, a_cbe}, 32'hA);
        chk("rd_data", rsp_rdata, 32'h1234_5678);
        chk("rd_status", {30'h0, rsp_status}, 32'h0);
        chk("rd_ad_oe", {31'h0, wr_oe}, 32'h0);
        chk("rd_parity", perr, 0);

        // No DEVSEL: abort on the 5th clock counted from ADDR
        tgt_mode = 1;
        do_cfg(1'b0, 4'd5, 6'd2, 4'hF, 32'h0, 1, lat, a_ad, a_cbe, wr_oe, perr);
        chk("ma_latency", lat, 8);
        chk("ma_data", rsp_rdata, 32'hFFFF_FFFF);
        chk("ma_status", {30'h0, rsp_status}, 32'h1);

        // 16 retries exhaust
        tgt_mode = 2; retry_target = 100; retry_base = retries_seen; rs0 = retries_seen; arb0 = arb_cnt;
        do_cfg(1'b1, 4'd1, 6'd1, 4'h3, 32'hCAFE_0001, 1, lat, a_ad, a_cbe, wr_oe, perr);
        chk("rx_status", {30'h0, rsp_status}, 32'h3);
        chk("rx_retries", retries_seen - rs0, 16);
        chk("rx_arbs", arb_cnt - arb0, 16);

        // 3 retries then data
        retry_target = 3; retry_base = retries_seen; arb0 = arb_cnt;
        tgt_rdata = 32'hA5A5_5A5A;
        do_cfg(1'b0, 4'd2, 6'd8, 4'hF, 32'h0, 1, lat, a_ad, a_cbe, wr_oe, perr);
        chk("r3_latency", lat, 17);
        chk("r3_status", {30'h0, rsp_status}, 32'h0);
        chk("r3_data", rsp_rdata, 32'hA5A5_5A5A);
        chk("r3_arbs", arb_cnt - arb0, 4);

        // Target abort
        tgt_mode = 3;
        do_cfg(1'b1, 4'd7, 6'd3, 4'hF, 32'h1111_2222, 1, lat, a_ad, a_cbe, wr_oe, perr);
        chk("ta_latency", lat, 6);
        chk("ta_status", {30'h0, rsp_status}, 32'h2);

        // Grant delayed by two clocks
        tgt_mode = 0;
        do_cfg(1'b1, 4'd4, 6'd9, 4'h1, 32'h0000_00FF, 3, lat, a_ad, a_cbe, wr_oe, perr);
        chk("gnt_latency", lat, 7);
        chk("gnt_addr", a_ad, 32'h0010_0024);

        // Reset in the middle of a stalled data phase
        tgt_mode = 4;
        @(posedge clk); #1;
        req_we = 1'b1; req_dev = 4'd6; req_reg = 6'd5; req_wdata = 32'h5555_AAAA; req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            req = 1'b0;
            if (data_phase) break;
        end
        chk("stall_in_data", {31'h0, data_phase}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ctl", {24'h0, req_n, frame_n_o, irdy_n_o, ad_oe, cbe_oe, ctl_oe, par_oe, req_done},
            32'h0000_00E0);
        @(posedge clk); #1;
        rst = 1'b1;
        tgt_mode = 0; tgt_rdata = 32'h0BAD_F00D;
        do_cfg(1'b0, 4'd15, 6'h3F, 4'hF, 32'h0, 1, lat, a_ad, a_cbe, wr_oe, perr);
        chk("post_rst_latency", lat, 5);
        chk("post_rst_addr", a_ad, 32'h8000_00FC);
        chk("post_rst_data", rsp_rdata, 32'h0BAD_F00D);
        chk("post_rst_parity", perr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
